// File: rtl/btb_pkg.sv
// btb_pkg: shared types and helpers for the branch target buffer controller.
//   btb_state_t      - controller states (SWEEP clears the table, IDLE serves lookups/updates)
//   DEFAULT_S_INDEX  - default number of index bits
//   DEFAULT_WIDTH    - default PC / target width
//   pc_index/pc_tag  - split a word-aligned PC into set index and tag fields
package btb_pkg;

  localparam int DEFAULT_S_INDEX = 4;
  localparam int DEFAULT_WIDTH   = 32;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } btb_state_t;

  // Index sits just above the two byte-offset bits; callers truncate to s_idx bits.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int s_idx);
    return (pc >> 2) & ((32'd1 << s_idx) - 32'd1);
  endfunction

  // Tag is everything above the index; callers truncate to 32-s_idx-2 bits.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int s_idx);
    return pc >> (s_idx + 2);
  endfunction

endpackage

// File: rtl/btb_if.sv
// btb_if: fetch lookup, execute update handshake and flush signals of the BTB.
//   fetch_pc/pred_hit/pred_target         - combinational lookup
//   upd_valid/upd_ready/upd_pc/upd_target/upd_taken - resolved branch update
//   flush_req/flush_busy                  - table invalidate request and status
// master: fetch/execute side; slave: btb_ctrl.
interface btb_if #(
  parameter int width = 32
);
  logic [31:0]      fetch_pc;
  logic             pred_hit;
  logic [width-1:0] pred_target;
  logic             upd_valid;
  logic             upd_ready;
  logic [31:0]      upd_pc;
  logic [width-1:0] upd_target;
  logic             upd_taken;
  logic             flush_req;
  logic             flush_busy;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
    input  pred_hit, pred_target, upd_ready, flush_busy
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
    output pred_hit, pred_target, upd_ready, flush_busy
  );
endinterface

// File: rtl/btb_array.sv
// btb_array: one field of the BTB storage, 2**s_index entries of width bits.
//   clk      - write clock
//   load_i   - write enable
//   rindex_i - combinational read index
//   windex_i - write index
//   din_i    - write data
//   dout_o   - read data, bypassed from din_i when writing the entry being read
module btb_array #(
  parameter int s_index = 4,
  parameter int width   = 1
) (
  input  logic               clk,
  input  logic               load_i,
  input  logic [s_index-1:0] rindex_i,
  input  logic [s_index-1:0] windex_i,
  input  logic [width-1:0]   din_i,
  output logic [width-1:0]   dout_o
);

  logic [width-1:0] mem_q [2**s_index];

  // Storage write; contents are not reset, the controller's sweep clears valid bits.
  always_ff @(posedge clk) begin
    if (load_i) begin
      mem_q[windex_i] <= din_i;
    end
  end

  // Read with write-through so a lookup sees an entry in the same cycle it is written.
  always_comb begin
    dout_o = mem_q[rindex_i];
    if (load_i && (windex_i == rindex_i)) begin
      dout_o = din_i;
    end
  end

endmodule

// File: rtl/btb_ctrl.sv
// btb_ctrl: branch target buffer controller.
//   clk   - clock, all state on posedge
//   rst_n - synchronous active-low reset
//   bus   - btb_if slave: lookup, update handshake, flush request/busy
// Owns valid/tag/target arrays, a one-entry update buffer, and the invalidate
// sweep that runs after reset and on flush.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int s_index = DEFAULT_S_INDEX,
  parameter int width   = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  btb_if.slave bus
);

  localparam int s_tag = 32 - s_index - 2;
  localparam logic [s_index-1:0] LAST_SET = '1;

  btb_state_t         state_q, state_d;
  logic [s_index-1:0] sweep_cnt_q, sweep_cnt_d;
  logic               buf_valid_q, buf_valid_d;
  logic [s_index-1:0] buf_index_q, buf_index_d;
  logic [s_tag-1:0]   buf_tag_q, buf_tag_d;
  logic [width-1:0]   buf_target_q, buf_target_d;

  logic               load;
  logic [s_index-1:0] windex;
  logic [s_index-1:0] rindex;
  logic               valid_din;
  logic               valid_out;
  logic [s_tag-1:0]   tag_out;
  logic [width-1:0]   target_out;
  logic [s_tag-1:0]   fetch_tag;

  assign rindex    = s_index'(pc_index(bus.fetch_pc, s_index));
  assign fetch_tag = s_tag'(pc_tag(bus.fetch_pc, s_index));

  btb_array #(.s_index(s_index), .width(1)) u_valid (
    .clk(clk), .load_i(load), .rindex_i(rindex), .windex_i(windex),
    .din_i(valid_din), .dout_o(valid_out)
  );

  btb_array #(.s_index(s_index), .width(s_tag)) u_tag (
    .clk(clk), .load_i(load), .rindex_i(rindex), .windex_i(windex),
    .din_i(buf_tag_q), .dout_o(tag_out)
  );

  btb_array #(.s_index(s_index), .width(width)) u_target (
    .clk(clk), .load_i(load), .rindex_i(rindex), .windex_i(windex),
    .din_i(buf_target_q), .dout_o(target_out)
  );

  // State, sweep counter and update buffer; reset restarts the sweep and drops the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SWEEP;
      sweep_cnt_q <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      buf_valid_q <= buf_valid_d;
    end
    buf_index_q  <= buf_index_d;
    buf_tag_q    <= buf_tag_d;
    buf_target_q <= buf_target_d;
  end

  // Next state and the single write port. Sweep writes own the port while sweeping;
  // in IDLE a flush discards the buffer unwritten, otherwise a full buffer drains.
  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    buf_valid_d  = buf_valid_q;
    buf_index_d  = buf_index_q;
    buf_tag_d    = buf_tag_q;
    buf_target_d = buf_target_q;
    load         = 1'b0;
    windex       = sweep_cnt_q;
    valid_din    = 1'b0;

    bus.upd_ready   = (state_q == IDLE) && !buf_valid_q && !bus.flush_req;
    bus.flush_busy  = (state_q == SWEEP);
    bus.pred_hit    = (state_q == IDLE) && valid_out && (tag_out == fetch_tag);
    bus.pred_target = target_out;

    case (state_q)
      SWEEP: begin
        load = 1'b1;
        if (bus.flush_req) begin
          sweep_cnt_d = '0;
        end else if (sweep_cnt_q == LAST_SET) begin
          sweep_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (bus.flush_req) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
          buf_valid_d = 1'b0;
        end else begin
          if (buf_valid_q) begin
            load        = 1'b1;
            windex      = buf_index_q;
            valid_din   = 1'b1;
            buf_valid_d = 1'b0;
          end
          // Not-taken branches complete the handshake but never fill the buffer.
          if (bus.upd_valid && bus.upd_ready && bus.upd_taken) begin
            buf_valid_d  = 1'b1;
            buf_index_d  = s_index'(pc_index(bus.upd_pc, s_index));
            buf_tag_d    = s_tag'(pc_tag(bus.upd_pc, s_index));
            buf_target_d = bus.upd_target;
          end
        end
      end
      default: state_d = SWEEP;
    endcase

    // No write is issued in a reset cycle, whatever state was current.
    if (!rst_n) begin
      load = 1'b0;
    end
  end

endmodule
